// File: rtl/dma_copy_ctrl.sv
// Word-by-word memory-to-memory copy sequencer driving the DMA master wrapper's
// request interface: one read, then one write per 32-bit word, with sticky completion flag.
module dma_copy_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_abort,
  input  logic              cfg_irq_clr,
  output logic              busy,
  output logic              done_irq,
  output logic [LEN_W-1:0]  words_done,
  output logic              R_req,
  output logic [ADDR_W-1:0] DMA_R_ADDR,
  input  logic [DATA_W-1:0] DMA_R_DATA,
  input  logic              R_valid,
  output logic              W_req,
  output logic [ADDR_W-1:0] DMA_W_ADDR,
  output logic [DATA_W-1:0] DMA_W_DATA,
  input  logic              W_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  words_cnt;
  logic [DATA_W-1:0] data_buf;
  logic              abort_pending;
  logic              irq_q;
  logic              last_word;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  // Natural wrap at the top of the address space is intended.
  function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(4);
  endfunction

  // An abort arriving in the same cycle as W_done also ends the transfer here.
  assign last_word = ((words_cnt + LEN_W'(1)) == len_q) || abort_pending || cfg_abort;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = (cfg_len == '0) ? FIN : RD_REQ;
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: if (R_valid) state_nxt = WR_REQ;
      WR_REQ:  state_nxt = WR_WAIT;
      WR_WAIT: if (W_done) state_nxt = last_word ? FIN : RD_REQ;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cur_src   <= '0;
      cur_dst   <= '0;
      len_q     <= '0;
      words_cnt <= '0;
      data_buf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            cur_src   <= word_align(cfg_src);
            cur_dst   <= word_align(cfg_dst);
            len_q     <= cfg_len;
            words_cnt <= '0;
          end
        end
        RD_WAIT: begin
          if (R_valid) data_buf <= DMA_R_DATA;
        end
        WR_WAIT: begin
          if (W_done) begin
            words_cnt <= words_cnt + LEN_W'(1);
            cur_src   <= next_word(cur_src);
            cur_dst   <= next_word(cur_dst);
          end
        end
        default: ;
      endcase
    end
  end

  // Abort is only a request to stop at the next word boundary; clearing on
  // the way back to IDLE keeps a stale abort from cutting the next transfer.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      abort_pending <= 1'b0;
    end else if (state_nxt == IDLE) begin
      abort_pending <= 1'b0;
    end else if (cfg_abort && (state != IDLE)) begin
      abort_pending <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      irq_q <= 1'b0;
    end else if (state == FIN) begin
      irq_q <= 1'b1;
    end else if (cfg_irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign busy       = (state != IDLE);
  assign R_req      = (state == RD_REQ);
  assign W_req      = (state == WR_REQ);
  assign done_irq   = irq_q;
  assign words_done = words_cnt;
  assign DMA_R_ADDR = cur_src;
  assign DMA_W_ADDR = cur_dst;
  assign DMA_W_DATA = data_buf;

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Bench for dma_copy_ctrl: behavioural wrapper responders with a read/write
// scoreboard, a table of copy jobs, and hand-written race/reset sequences.
module tb_dma_copy_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          cfg_start;
  logic [AW-1:0] cfg_src;
  logic [AW-1:0] cfg_dst;
  logic [LW-1:0] cfg_len;
  logic          cfg_abort;
  logic          cfg_irq_clr;
  logic          busy;
  logic          done_irq;
  logic [LW-1:0] words_done;
  logic          R_req;
  logic [AW-1:0] DMA_R_ADDR;
  logic [DW-1:0] DMA_R_DATA;
  logic          R_valid;
  logic          W_req;
  logic [AW-1:0] DMA_W_ADDR;
  logic [DW-1:0] DMA_W_DATA;
  logic          W_done;

  dma_copy_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cfg_start(cfg_start), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_abort(cfg_abort), .cfg_irq_clr(cfg_irq_clr),
    .busy(busy), .done_irq(done_irq), .words_done(words_done),
    .R_req(R_req), .DMA_R_ADDR(DMA_R_ADDR), .DMA_R_DATA(DMA_R_DATA), .R_valid(R_valid),
    .W_req(W_req), .DMA_W_ADDR(DMA_W_ADDR), .DMA_W_DATA(DMA_W_DATA), .W_done(W_done)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;
  int rd_delay = 0;
  int wr_delay = 0;
  int abort_tgt = -1;
  int rd_seen = 0;
  int wr_seen = 0;
  logic [31:0] rd_q[$];
  logic [63:0] wr_q[$];

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          abort_at;
    int          rdd;
    int          wrd;
    int          exp_words;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
  endfunction

  task automatic push_expect(input logic [31:0] src, input logic [31:0] dst, input int n);
    logic [31:0] s;
    logic [31:0] d;
    s = {src[31:2], 2'b00};
    d = {dst[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(s);
      wr_q.push_back({d, mem_word(s)});
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    cfg_src = s;
    cfg_dst = d;
    cfg_len = l;
    cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge ACLK);
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL idle_timeout got=busy want=idle");
    end
  endtask

  task automatic clear_irq();
    cfg_irq_clr = 1'b1;
    @(negedge ACLK);
    cfg_irq_clr = 1'b0;
    check("irq_clr", 64'(done_irq), 64'(1'b0));
  endtask

  // Read side of the wrapper model; also injects the abort pulse.
  initial begin : rd_resp
    logic [31:0] a;
    R_valid = 1'b0;
    DMA_R_DATA = '0;
    cfg_abort = 1'b0;
    forever begin
      @(negedge ACLK);
      if (ARESETn === 1'b1 && R_req === 1'b1) begin
        a = DMA_R_ADDR;
        rd_seen++;
        if (rd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected got=%h want=none", a);
        end else begin
          check("rd_addr", 64'(a), 64'(rd_q.pop_front()));
        end
        @(negedge ACLK);
        if (rd_seen == abort_tgt) cfg_abort = 1'b1;
        for (int i = 0; i < rd_delay; i++) begin
          check("rd_hold_addr", 64'(DMA_R_ADDR), 64'(a));
          check("rd_req_pulse", 64'(R_req), 64'(1'b0));
          @(negedge ACLK);
          cfg_abort = 1'b0;
          if (ARESETn !== 1'b1) break;
        end
        if (ARESETn === 1'b1) begin
          R_valid = 1'b1;
          DMA_R_DATA = mem_word(a);
          @(negedge ACLK);
          R_valid = 1'b0;
        end
        cfg_abort = 1'b0;
      end
    end
  end

  // Write side of the wrapper model; checks each write against the scoreboard.
  initial begin : wr_resp
    logic [63:0] w;
    logic ok;
    W_done = 1'b0;
    forever begin
      @(negedge ACLK);
      if (ARESETn === 1'b1 && W_req === 1'b1) begin
        w = {DMA_W_ADDR, DMA_W_DATA};
        wr_seen++;
        if (wr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected got=%h want=none", w);
        end else begin
          check("wr_addr_data", w, wr_q.pop_front());
        end
        @(negedge ACLK);
        ok = 1'b1;
        for (int i = 0; i < wr_delay; i++) begin
          check("wr_hold", {DMA_W_ADDR, DMA_W_DATA}, w);
          check("wr_req_pulse", 64'(W_req), 64'(1'b0));
          @(negedge ACLK);
          if (ARESETn !== 1'b1) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok && ARESETn === 1'b1) begin
          W_done = 1'b1;
          @(negedge ACLK);
          W_done = 1'b0;
        end
      end
    end
  end

  initial begin : main
    int n;
    vecs[0] = '{32'h0000_1000, 32'h0000_2000, 16'd3,  0, 0,  0, 3};
    vecs[1] = '{32'h0000_1100, 32'h0000_2200, 16'd0,  0, 0,  0, 0};
    vecs[2] = '{32'hFFFF_FFFE, 32'h0000_3003, 16'd2,  0, 0,  0, 2};
    vecs[3] = '{32'h0000_4000, 32'h0000_5000, 16'd10, 2, 0,  0, 2};
    vecs[4] = '{32'h0000_0100, 32'hFFFF_FFF8, 16'd3,  0, 2,  3, 3};
    vecs[5] = '{32'h0000_0600, 32'h0000_0700, 16'd1,  0, 20, 0, 1};
    vecs[6] = '{32'h0001_0000, 32'h0002_0000, 16'd4,  0, 1,  1, 4};

    ARESETn = 1'b0;
    cfg_start = 1'b0;
    cfg_src = '0;
    cfg_dst = '0;
    cfg_len = '0;
    cfg_irq_clr = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_irq", 64'(done_irq), 64'(1'b0));
    check("rst_words", 64'(words_done), 64'(0));
    check("rst_reqs", 64'({R_req, W_req}), 64'(2'b00));
    check("rst_addrs", {DMA_R_ADDR, DMA_W_ADDR}, 64'(0));
    check("rst_wdata", 64'(DMA_W_DATA), 64'(0));
    ARESETn = 1'b1;
    @(negedge ACLK);

    for (int v = 0; v < 7; v++) begin
      rd_delay = vecs[v].rdd;
      wr_delay = vecs[v].wrd;
      abort_tgt = (vecs[v].abort_at > 0) ? rd_seen + vecs[v].abort_at : -1;
      clear_irq();
      push_expect(vecs[v].src, vecs[v].dst, vecs[v].exp_words);
      launch(vecs[v].src, vecs[v].dst, vecs[v].len);
      check("vec_busy_start", 64'(busy), 64'(1'b1));
      wait_idle(n);
      check("vec_busy_cycles", 64'(n),
            64'(vecs[v].exp_words * (4 + vecs[v].rdd + vecs[v].wrd) + 1));
      check("vec_irq", 64'(done_irq), 64'(1'b1));
      check("vec_words", 64'(words_done), 64'(vecs[v].exp_words));
      check("vec_queues", 64'(rd_q.size() + wr_q.size()), 64'(0));
      @(negedge ACLK);
    end

    // irq clear racing the FIN set
    rd_delay = 0;
    wr_delay = 0;
    abort_tgt = -1;
    clear_irq();
    push_expect(32'h0000_A000, 32'h0000_B000, 1);
    launch(32'h0000_A000, 32'h0000_B000, 16'd1);
    repeat (4) @(negedge ACLK);
    check("race_in_fin", 64'({busy, R_req, W_req}), 64'(3'b100));
    cfg_irq_clr = 1'b1;
    @(negedge ACLK);
    cfg_irq_clr = 1'b0;
    check("race_irq_kept", 64'(done_irq), 64'(1'b1));
    check("race_idle", 64'(busy), 64'(1'b0));
    clear_irq();
    check("race_words", 64'(words_done), 64'(1));

    // start while busy must not disturb the running job
    rd_delay = 3;
    push_expect(32'h0000_8000, 32'h0000_9000, 2);
    launch(32'h0000_8000, 32'h0000_9000, 16'd2);
    @(negedge ACLK);
    launch(32'hAAAA_0000, 32'hBBBB_0000, 16'd7);
    wait_idle(n);
    check("ign_words", 64'(words_done), 64'(2));
    check("ign_irq", 64'(done_irq), 64'(1'b1));
    check("ign_queues", 64'(rd_q.size() + wr_q.size()), 64'(0));
    @(negedge ACLK);

    // asynchronous reset during the second word's WR_WAIT
    rd_delay = 0;
    wr_delay = 30;
    n = wr_seen + 2;
    push_expect(32'h0000_C000, 32'h0000_D000, 2);
    wr_delay = 0;
    launch(32'h0000_C000, 32'h0000_D000, 16'd2);
    for (int i = 0; i < 200 && wr_seen < n - 1; i++) @(negedge ACLK);
    wr_delay = 30;
    for (int i = 0; i < 200 && wr_seen < n; i++) @(negedge ACLK);
    check("rst_reached_wr2", 64'(wr_seen), 64'(n));
    @(negedge ACLK);
    check("pre_rst_state", 64'({busy, W_req, R_req}), 64'(3'b100));
    check("pre_rst_words", 64'(words_done), 64'(1));
    check("pre_rst_irq", 64'(done_irq), 64'(1'b1));
    #1 ARESETn = 1'b0;
    #1;
    check("mid_rst_busy_req", 64'({busy, W_req, R_req}), 64'(3'b000));
    check("mid_rst_words", 64'(words_done), 64'(0));
    check("mid_rst_irq", 64'(done_irq), 64'(1'b0));
    check("mid_rst_wbus", {DMA_W_ADDR, DMA_W_DATA}, 64'(0));
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (3) @(negedge ACLK);
    check("post_rst_idle", 64'(busy), 64'(1'b0));
    check("post_rst_queues", 64'(rd_q.size() + wr_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
